// File: rtl/m_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : m_ctrl_fsm
// Purpose  : Multicycle control unit for the MIPS-subset CPU. Sequences the
//            datapath through fetch, decode, execute, memory and write-back.
//            Every control strobe is decoded from the current state and the
//            IR contents. Fetch, load and store stall while MIO_ready is low.
// Ports    : clk, reset (sync, active-high), MIO_ready, Inst[31:0], zero
//            -> IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch,
//               RegDst[1:0], MemtoReg[1:0], ALUSrcB[1:0], PCSource[1:0],
//               ALU_operation[2:0], MemRead, MemWrite, CPU_MIO, illegal_inst,
//               state[4:0]
// Options  : M_CTRL_ERR_TRAP_EN - when defined, an illegal instruction traps
//            into HALT (code 16), which holds until reset. When undefined,
//            the illegal instruction behaves as a NOP.
// Revision : 1.0 - initial release
// ============================================================================
module m_ctrl_fsm #(
  parameter logic [2:0] ALU_AND = 3'b000,
  parameter logic [2:0] ALU_OR  = 3'b001,
  parameter logic [2:0] ALU_ADD = 3'b010,
  parameter logic [2:0] ALU_XOR = 3'b011,
  parameter logic [2:0] ALU_NOR = 3'b100,
  parameter logic [2:0] ALU_LUI = 3'b101,
  parameter logic [2:0] ALU_SUB = 3'b110,
  parameter logic [2:0] ALU_SLT = 3'b111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MIO_ready,
  input  logic [31:0] Inst,
  input  logic        zero,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [2:0]  ALU_operation,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        CPU_MIO,
  output logic        illegal_inst,
  output logic [4:0]  state
);

  localparam logic [4:0] S_IF    = 5'd0;
  localparam logic [4:0] S_ID    = 5'd1;
  localparam logic [4:0] S_MA    = 5'd2;
  localparam logic [4:0] S_MRD   = 5'd3;
  localparam logic [4:0] S_WB_LW = 5'd4;
  localparam logic [4:0] S_MWR   = 5'd5;
  localparam logic [4:0] S_EX_R  = 5'd6;
  localparam logic [4:0] S_WB_R  = 5'd7;
  localparam logic [4:0] S_BR    = 5'd8;
  localparam logic [4:0] S_J     = 5'd9;
  localparam logic [4:0] S_EX_I  = 5'd10;
  localparam logic [4:0] S_WB_I  = 5'd11;
  localparam logic [4:0] S_LUI   = 5'd12;
  localparam logic [4:0] S_JAL   = 5'd13;
  localparam logic [4:0] S_JR    = 5'd14;
  localparam logic [4:0] S_ILL   = 5'd15;
`ifdef M_CTRL_ERR_TRAP_EN
  localparam logic [4:0] S_HALT  = 5'd16;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  logic [4:0] next_state;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [2:0] funct_op;
  logic       funct_ok;
  logic [2:0] imm_op;
  logic       imm_ok;

  assign opcode = Inst[31:26];
  assign funct  = Inst[5:0];

  // Branch resolution (zero vs. Branch) happens in the datapath; register
  // fields are likewise consumed there.
  logic unused_ok;
  assign unused_ok = &{1'b0, zero, Inst[25:6]};

  // ALU op for R-type arithmetic; funct_ok marks the supported functs.
  always_comb begin
    funct_op = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      6'b100000: funct_op = ALU_ADD;
      6'b100010: funct_op = ALU_SUB;
      6'b100100: funct_op = ALU_AND;
      6'b100101: funct_op = ALU_OR;
      6'b100110: funct_op = ALU_XOR;
      6'b100111: funct_op = ALU_NOR;
      6'b101010: funct_op = ALU_SLT;
      default:   funct_ok = 1'b0;
    endcase
  end

  // ALU op for immediate arithmetic.
  always_comb begin
    imm_op = ALU_ADD;
    imm_ok = 1'b1;
    case (opcode)
      OP_ADDI: imm_op = ALU_ADD;
      OP_SLTI: imm_op = ALU_SLT;
      OP_ANDI: imm_op = ALU_AND;
      OP_ORI:  imm_op = ALU_OR;
      OP_XORI: imm_op = ALU_XOR;
      default: imm_ok = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IF;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = S_IF;
    case (state)
      S_IF:  next_state = MIO_ready ? S_ID : S_IF;
      S_ID: begin
        case (opcode)
          OP_LW, OP_SW:   next_state = S_MA;
          OP_RTYPE: begin
            if (funct == FN_JR) next_state = S_JR;
            else if (funct_ok)  next_state = S_EX_R;
            else                next_state = S_ILL;
          end
          OP_BEQ, OP_BNE: next_state = S_BR;
          OP_J:           next_state = S_J;
          OP_JAL:         next_state = S_JAL;
          OP_LUI:         next_state = S_LUI;
          default:        next_state = imm_ok ? S_EX_I : S_ILL;
        endcase
      end
      S_MA:   next_state = (opcode == OP_SW) ? S_MWR : S_MRD;
      S_MRD:  next_state = MIO_ready ? S_WB_LW : S_MRD;
      S_MWR:  next_state = MIO_ready ? S_IF : S_MWR;
      S_EX_R: next_state = S_WB_R;
      S_EX_I: next_state = S_WB_I;
`ifdef M_CTRL_ERR_TRAP_EN
      S_ILL:  next_state = S_HALT;
      S_HALT: next_state = S_HALT;
`else
      S_ILL:  next_state = S_IF;
`endif
      default: next_state = S_IF;
    endcase
  end

  // Output decode
  always_comb begin
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    Branch        = 1'b0;
    RegDst        = 2'b00;
    MemtoReg      = 2'b00;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    ALU_operation = ALU_ADD;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    illegal_inst  = 1'b0;
    case (state)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
        IRWrite = MIO_ready;
      end
      S_ID: begin
        // Branch target computed speculatively into ALUOut.
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b11;
      end
      S_MA:    ALUSrcB = 2'b10;
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_WB_LW: begin
        MemtoReg = 2'b01;
        RegWrite = 1'b1;
      end
      S_MWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EX_R:  ALU_operation = funct_op;
      S_WB_R: begin
        ALU_operation = funct_op;
        RegDst        = 2'b01;
        RegWrite      = 1'b1;
      end
      S_BR: begin
        ALU_operation = ALU_SUB;
        PCWriteCond   = 1'b1;
        PCSource      = 2'b01;
        Branch        = (opcode == OP_BEQ);
      end
      S_J: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_EX_I: begin
        ALUSrcB       = 2'b10;
        ALU_operation = imm_op;
      end
      S_WB_I: begin
        ALUSrcB       = 2'b10;
        ALU_operation = imm_op;
        RegWrite      = 1'b1;
      end
      S_LUI: begin
        ALUSrcB       = 2'b10;
        ALU_operation = ALU_LUI;
        MemtoReg      = 2'b10;
        RegWrite      = 1'b1;
      end
      S_JAL: begin
        // PC was already incremented in IF, so PC+4 lands in $31.
        RegDst   = 2'b10;
        MemtoReg = 2'b11;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_JR: begin
        ALU_operation = ALU_OR;  // rs | $0 passes rs through to the PC
        PCWrite       = 1'b1;
      end
      S_ILL:   illegal_inst = 1'b1;
`ifdef M_CTRL_ERR_TRAP_EN
      S_HALT: begin
        // Everything idle: PC frozen until reset.
      end
`endif
      default: ALU_operation = 3'b000;
    endcase
  end

  assign CPU_MIO = MemRead | MemWrite;

endmodule
`default_nettype wire

// File: tb/tb_m_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_ctrl_fsm
// Purpose  : Self-checking bench for m_ctrl_fsm. Each instruction is turned
//            into an expected step list (state + MIO_ready) from its class,
//            then replayed; every step checks the state and all outputs
//            against a table model of the control strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        MIO_ready;
  logic [31:0] Inst;
  logic        zero;
  logic        IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [2:0]  ALU_operation;
  logic        MemRead, MemWrite, CPU_MIO, illegal_inst;
  logic [4:0]  state;

  int total = 0;
  int bad   = 0;

  localparam int IF = 0, ID = 1, MA = 2, MRD = 3, WBLW = 4, MWR = 5, EXR = 6,
                 WBR = 7, BR = 8, JMP = 9, EXI = 10, WBI = 11, LUI = 12,
                 JAL = 13, JR = 14, ILL = 15, HALT = 16;

  typedef struct {
    logic mio;
    int   st;
  } step_t;

  step_t q[$];

  m_ctrl_fsm dut (
    .clk(clk), .reset(reset), .MIO_ready(MIO_ready), .Inst(Inst), .zero(zero),
    .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALU_operation(ALU_operation), .MemRead(MemRead),
    .MemWrite(MemWrite), .CPU_MIO(CPU_MIO), .illegal_inst(illegal_inst),
    .state(state)
  );

  always #5 clk = ~clk;

  logic [21:0] dut_out;
  assign dut_out = {IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond,
                    Branch, RegDst, MemtoReg, ALUSrcB, PCSource, ALU_operation,
                    MemRead, MemWrite, CPU_MIO, illegal_inst};

  function automatic logic [2:0] rtype_op(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b100110: return 3'b011;
      6'b100111: return 3'b100;
      default:   return 3'b111;  // slt
    endcase
  endfunction

  function automatic bit rtype_legal(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                     6'b100110, 6'b100111, 6'b101010};
  endfunction

  function automatic logic [2:0] itype_op(input logic [5:0] o);
    case (o)
      6'b001010: return 3'b111;
      6'b001100: return 3'b000;
      6'b001101: return 3'b001;
      6'b001110: return 3'b011;
      default:   return 3'b010;  // addi
    endcase
  endfunction

  // Expected outputs for one state, straight from the state/output table.
  function automatic logic [21:0] model_out(input logic mio, input int st,
                                            input logic [31:0] ins);
    logic iord, irw, regw, srca, pcw, pcwc, br, mr, mw, ill;
    logic [1:0] rdst, m2r, srcb, pcsrc;
    logic [2:0] alu;
    {iord, irw, regw, srca, pcw, pcwc, br, mr, mw, ill} = '0;
    {rdst, m2r, srcb, pcsrc} = '0;
    alu = 3'b010;
    case (st)
      IF:   begin mr = 1; srca = 1; srcb = 2'b01; pcw = 1; irw = mio; end
      ID:   begin srca = 1; srcb = 2'b11; end
      MA:   srcb = 2'b10;
      MRD:  begin mr = 1; iord = 1; end
      WBLW: begin m2r = 2'b01; regw = 1; end
      MWR:  begin mw = 1; iord = 1; end
      EXR:  alu = rtype_op(ins[5:0]);
      WBR:  begin alu = rtype_op(ins[5:0]); rdst = 2'b01; regw = 1; end
      BR:   begin alu = 3'b110; pcwc = 1; pcsrc = 2'b01; br = (ins[31:26] == 6'b000100); end
      JMP:  begin pcw = 1; pcsrc = 2'b10; end
      EXI:  begin srcb = 2'b10; alu = itype_op(ins[31:26]); end
      WBI:  begin srcb = 2'b10; alu = itype_op(ins[31:26]); regw = 1; end
      LUI:  begin srcb = 2'b10; alu = 3'b101; m2r = 2'b10; regw = 1; end
      JAL:  begin rdst = 2'b10; m2r = 2'b11; regw = 1; pcw = 1; pcsrc = 2'b10; end
      JR:   begin alu = 3'b001; pcw = 1; end
      ILL:  ill = 1;
      default: ;  // HALT: all idle
    endcase
    return {iord, irw, regw, srca, pcw, pcwc, br, rdst, m2r, srcb, pcsrc, alu,
            mr, mw, mr | mw, ill};
  endfunction

  function automatic logic rbit();
    logic [31:0] r;
    r = $urandom;
    return r[0];
  endfunction

  // Wait state: w cycles not ready, then one ready cycle.
  task automatic push_wait(input int st, input int w);
    for (int i = 0; i < w; i++) q.push_back('{1'b0, st});
    q.push_back('{1'b1, st});
  endtask

  task automatic push_one(input int st);
    q.push_back('{rbit(), st});
  endtask

  // Expected step list for one instruction, derived from its class.
  task automatic build(input logic [31:0] ins, input int if_w, input int mem_w);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    push_wait(IF, if_w);
    push_one(ID);
    case (op)
      6'b100011: begin push_one(MA); push_wait(MRD, mem_w); push_one(WBLW); end
      6'b101011: begin push_one(MA); push_wait(MWR, mem_w); end
      6'b000000: begin
        if (fn == 6'b001000)      push_one(JR);
        else if (rtype_legal(fn)) begin push_one(EXR); push_one(WBR); end
        else                      push_one(ILL);
      end
      6'b000100, 6'b000101: push_one(BR);
      6'b000010: push_one(JMP);
      6'b000011: push_one(JAL);
      6'b001111: push_one(LUI);
      6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110: begin
        push_one(EXI); push_one(WBI);
      end
      default: push_one(ILL);
    endcase
  endtask

  // Replays the step list; called and returns at posedge+1.
  task automatic replay(input logic [31:0] ins, input string tag);
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      MIO_ready = s.mio;
      Inst = ins;
      zero = rbit();
      #1;
      total++;
      if (state !== 5'(s.st)) begin
        bad++;
        $display("FAIL %s state got=%0d want=%0d", tag, state, s.st);
      end
      total++;
      if (dut_out !== model_out(s.mio, s.st, ins)) begin
        bad++;
        $display("FAIL %s outputs in state %0d got=%h want=%h", tag, s.st,
                 dut_out, model_out(s.mio, s.st, ins));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_inst(input logic [31:0] ins, input int if_w,
                          input int mem_w, input string tag);
    build(ins, if_w, mem_w);
    replay(ins, tag);
  endtask

  task automatic check_state_if(input string tag);
    total++;
    if (state !== 5'd0) begin
      bad++;
      $display("FAIL %s state got=%0d want=0", tag, state);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    MIO_ready = 1'b1;
    Inst = 32'h0;
    zero = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_state_if("reset");
    total++;
    if (dut_out !== model_out(1'b1, IF, 32'h0)) begin
      bad++;
      $display("FAIL reset outputs got=%h want=%h", dut_out, model_out(1'b1, IF, 32'h0));
    end
    reset = 1'b0;
  endtask

  task automatic test_lw_wait();
    run_inst(32'h8C080004, 0, 3, "lw_wait");
    run_inst(32'hAC080004, 2, 2, "sw_wait");
  endtask

  task automatic test_sub_beq();
    run_inst(32'h00A63022, 0, 0, "sub");
    run_inst(32'h1000FFFF, 0, 0, "beq");
    run_inst(32'h1400FFFF, 1, 0, "bne");
  endtask

  task automatic test_jal_jr();
    run_inst(32'h0C000010, 0, 0, "jal");
    run_inst(32'h03E00008, 0, 0, "jr");
    run_inst(32'h08000004, 0, 0, "j");
  endtask

  task automatic test_lui();
    run_inst(32'h3C011234, 0, 0, "lui");
  endtask

  task automatic test_reset_midwait();
    // Stall in MRD, then reset.
    q.push_back('{1'b1, IF});
    push_one(ID);
    push_one(MA);
    q.push_back('{1'b0, MRD});
    q.push_back('{1'b0, MRD});
    replay(32'h8C080004, "mrd_stall");
    reset = 1'b1;
    MIO_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_state_if("reset_in_mrd");
    // Stall in MWR, then reset.
    q.push_back('{1'b1, IF});
    push_one(ID);
    push_one(MA);
    q.push_back('{1'b0, MWR});
    replay(32'hAC080004, "mwr_stall");
    reset = 1'b1;
    MIO_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_state_if("reset_in_mwr");
  endtask

  task automatic test_illegal();
    build(32'hFC000000, 0, 0);
`ifdef M_CTRL_ERR_TRAP_EN
    for (int i = 0; i < 10; i++) q.push_back('{rbit(), HALT});
    replay(32'hFC000000, "illegal_halt");
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_state_if("halt_reset");
    run_inst(32'h00A63022, 0, 0, "after_halt");
`else
    replay(32'hFC000000, "illegal");
    run_inst(32'h00A6303F, 0, 0, "bad_funct");
    run_inst(32'h00A63022, 0, 0, "after_illegal");
`endif
  endtask

  task automatic test_random();
    logic [5:0] ops[13] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                            6'b000101, 6'b000010, 6'b000011, 6'b001000,
                            6'b001010, 6'b001100, 6'b001101, 6'b001110,
                            6'b001111};
    logic [5:0] fns[8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                           6'b100110, 6'b100111, 6'b101010, 6'b001000};
    logic [31:0] r, ins;
    logic [5:0] op;
    for (int n = 0; n < 80; n++) begin
      r = $urandom;
      op = ops[$urandom_range(0, 12)];
      if (op == 6'b000000) ins = {op, r[25:6], fns[$urandom_range(0, 7)]};
      else                 ins = {op, r[25:0]};
`ifndef M_CTRL_ERR_TRAP_EN
      if ($urandom_range(0, 9) == 0) ins = {6'b111111, r[25:0]};
`endif
      run_inst(ins, $urandom_range(0, 3), $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_sub_beq();
    test_jal_jr();
    test_lui();
    test_reset_midwait();
    test_random();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/m_ctrl_fsm.md
Name: m_ctrl_fsm

Overview:
Multicycle control unit for the MIPS-subset CPU. It sequences the multicycle datapath: instruction fetch, decode, execute, memory and write-back. It generates every datapath control strobe from the current state and the instruction register contents, and stalls on memory using MIO_ready. It sits beside the datapath inside the CPU top, and its memory strobes go to the MIO bus.

Parameters:
ALU_AND, 3'b000, ALU_operation code for AND
ALU_OR, 3'b001, code for OR
ALU_ADD, 3'b010, code for ADD
ALU_XOR, 3'b011, code for XOR
ALU_NOR, 3'b100, code for NOR
ALU_LUI, 3'b101, code for B<<16
ALU_SUB, 3'b110, code for SUB
ALU_SLT, 3'b111, code for signed set-less-than

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
MIO_ready  in  1  memory/IO transfer complete this cycle
Inst  in  32  IR contents: opcode [31:26], funct [5:0]
zero  in  1  ALU zero flag
IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch  out  1 each  datapath strobes
RegDst, MemtoReg, ALUSrcB, PCSource  out  2 each  datapath mux selects
ALU_operation  out  3  ALU op code
MemRead, MemWrite, CPU_MIO  out  1 each  bus strobes; CPU_MIO = MemRead|MemWrite
illegal_inst  out  1  one-cycle pulse when an unsupported instruction is decoded
state  out  5  current state code, for debug display

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
- State register resets to IF (code 0). Outputs are decoded from state, plus MIO_ready in IF, so after the reset edge the outputs show IF values.
- Every strobe not listed for a state is 0. Every select not listed is 00. ALU_operation defaults to ALU_ADD.
- Supported ops:
  - R-type: add, sub, and, or, xor, nor, slt, jr.
  - Other opcodes: lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011, addi 001000, slti 001010, andi 001100, ori 001101, xori 001110, lui 001111.
  - Immediates are sign-extended by the datapath for all I-type ops; andi/ori/xori inherit this.
- States and outputs:
  - IF (0): MemRead=1, IorD=0, ALUSrcA=1, ALUSrcB=01, ALU_ADD, PCSource=00, PCWrite=1, IRWrite=MIO_ready. Stay while !MIO_ready; go to ID when MIO_ready.
  - ID (1): ALUSrcA=1, ALUSrcB=11, ALU_ADD (branch target into ALUOut). Next state by opcode: lw/sw→MA; R-type→EX_R, or JR if funct=001000; beq/bne→BR; j→J; jal→JAL; lui→LUI; addi/slti/andi/ori/xori→EX_I; anything else→ILL.
  - MA (2): ALUSrcA=0, ALUSrcB=10, ALU_ADD. Go to MRD for lw, MWR for sw.
  - MRD (3): MemRead=1, IorD=1. Stay until MIO_ready, then go to WB_LW.
  - WB_LW (4): RegDst=00, MemtoReg=01, RegWrite=1. Go to IF.
  - MWR (5): MemWrite=1, IorD=1. Stay until MIO_ready, then go to IF.
  - EX_R (6): ALUSrcA=0, ALUSrcB=00, op from funct (100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt). Go to WB_R. An unlisted funct goes from ID to ILL instead.
  - WB_R (7): RegDst=01, MemtoReg=00, RegWrite=1; ALU controls held. Go to IF.
  - BR (8): ALUSrcA=0, ALUSrcB=00, ALU_SUB, PCWriteCond=1, PCSource=01, Branch=1 for beq / 0 for bne. Go to IF.
  - J (9): PCWrite=1, PCSource=10. Go to IF.
  - EX_I (10): ALUSrcA=0, ALUSrcB=10, op addi→ADD, slti→SLT, andi→AND, ori→OR, xori→XOR. Go to WB_I.
  - WB_I (11): RegDst=00, MemtoReg=00, RegWrite=1; ALU controls held. Go to IF.
  - LUI (12): ALUSrcB=10, ALU_LUI, MemtoReg=10, RegDst=00, RegWrite=1. Go to IF.
  - JAL (13): RegDst=10, MemtoReg=11, RegWrite=1, PCWrite=1, PCSource=10. Writes the already-incremented PC to $31. Go to IF.
  - JR (14): ALUSrcA=0, ALUSrcB=00, ALU_OR (rs|$0), PCSource=00, PCWrite=1. Go to IF.
  - ILL (15): illegal_inst=1 for this single cycle. Macro-dependent next state.
- Latency with zero-wait memory:
  - beq, bne, j, jal, jr, lui: 3 cycles.
  - R-type, I-type, sw: 4 cycles.
  - lw: 5 cycles.
  - Each extra !MIO_ready cycle in IF, MRD or MWR adds one cycle.
- Reset asserted in any state, including mid-wait in MRD/MWR: next state is IF. Reset has priority over all transitions.
- Codes 16..31 are unreachable; if entered they decode all outputs to 0 and go to IF.

Optional Feature:
M_CTRL_ERR_TRAP_EN
- Defined: ILL goes to HALT (16). HALT drives all strobes 0 and illegal_inst=0, and holds until reset, so the PC is frozen.
- Undefined: ILL returns to IF and the instruction executes as a NOP (PC already advanced in IF). HALT does not exist.

Test Plan:
- Reset held 2 cycles, MIO_ready=1 → state=0, MemRead=1, PCWrite=1, IRWrite=1, ALUSrcB=01, ALU_operation=010.
- Inst=0x8C080004 (lw), MIO_ready low for 3 cycles in MRD → state sequence 0,1,2,3,3,3,3,4,0; RegWrite=1 with MemtoReg=01 only in state 4.
- Inst=0x00A63022 (sub), then Inst=0x1000FFFF (beq) with zero=1 and then zero=0 → sub: EX_R ALU_operation=110, WB_R RegDst=01. beq: 3 cycles, PCWriteCond=1, Branch=1, PCSource=01 in BR.
- Inst=0x0C000010 (jal), then Inst=0x03E00008 (jr $31) → JAL: RegDst=10, MemtoReg=11, PCWrite=1. JR: ALU_operation=001, PCSource=00, PCWrite=1.
- Inst=0x3C011234 (lui) → states 0,1,12; ALU_operation=101, MemtoReg=10, RegWrite=1.
- Inst=0xFC000000 (illegal) → illegal_inst pulses once in state 15. Without macro: state returns to 0. With macro: state=16, stays 16 for 10 cycles, and returns to 0 only after reset.
